// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the integer register file with hazard scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NREAD = 2;
  localparam int ZERO_REG  = 0;

  // Base bit offset of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_base(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: write, issue, flush and read ports.
interface regfile_sb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [XLEN-1:0]         wr_data;
  logic [NREAD*AW-1:0]     rs_addr;
  logic [NREAD*XLEN-1:0]   rs_data;
  logic [NREAD-1:0]        rs_busy;
  logic                    iss_valid;
  logic [AW-1:0]           iss_rd;
  logic                    flush;
  logic                    any_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rs_addr, iss_valid, iss_rd, flush,
    input  rs_data, rs_busy, any_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs_addr, iss_valid, iss_rd, flush,
    output rs_data, rs_busy, any_busy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy bitmap: set on issue, cleared on writeback, wiped on flush or reset.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             any_busy
);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  // Issue is applied after the writeback clear so a newer producer wins a collision.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en)     busy_d[wr_addr] = 1'b0;
      if (iss_valid) busy_d[iss_rd]  = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with combinational bypassed read ports and a hazard scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = DEF_NREAD,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]  mem_d [NREGS];
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic             sb_any_busy;
  logic [XLEN-1:0]  rd_data [NREAD];
  logic             rd_busy [NREAD];

  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en && (bus.wr_addr != AW'(ZERO_REG))) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
    mem_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .busy      (busy_vec),
    .any_busy  (sb_any_busy)
  );

  // Same-cycle writeback forwards straight to decode, so the result is never busy.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          bypass;

    assign addr    = bus.rs_addr[slice_base(k, AW) +: AW];
    assign is_zero = (addr == AW'(ZERO_REG)) || !reset;
    assign bypass  = bus.wr_en && (bus.wr_addr == addr);

    assign rd_data[k] = is_zero ? '0 : (bypass ? bus.wr_data : mem_q[addr]);
    assign rd_busy[k] = is_zero ? 1'b0 : (bypass ? 1'b0 : busy_vec[addr]);
  end

  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rs_data[slice_base(k, XLEN) +: XLEN] = rd_data[k];
      bus.rs_busy[k]                           = rd_busy[k];
    end
  end

  assign bus.any_busy = sb_any_busy & reset;

endmodule
